// File: rtl/milano_pkg.sv
// Shared types and constants for the milano multiply-divide unit.
package milano_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_e;

  function automatic int unsigned div_cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, set quotient bit.
module div_iter_step
  import milano_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] dvsr_ext;
  logic           fits;
  // The remainder stays below the divisor, so its top bit never reaches the trial value.
  logic           rem_msb_unused;

  assign rem_msb_unused = rem[WIDTH];

  always_comb begin
    trial    = {rem[WIDTH-1:0], q[WIDTH-1]};
    dvsr_ext = {1'b0, divisor};
    fits     = (trial >= dvsr_ext);
    rem_next = fits ? (trial - dvsr_ext) : trial;
    q_next   = {q[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_iter.sv
// Iterative unsigned restoring divider, WIDTH steps per operation.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and dividend<divisor finish without iterating.
module div_iter
  import milano_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_done,
  output logic             div_busy
);

  localparam int unsigned CNT_W = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] q_next;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .divisor  (dvsr_r),
    .rem_next (rem_next),
    .q_next   (q_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      q_r      <= '0;
      rem_r    <= '0;
      dvsr_r   <= '0;
      div_done <= 1'b0;
      div_busy <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          div_done <= 1'b0;
          div_busy <= 1'b0;
          if (div_start) begin
            q_r      <= dividend;
            dvsr_r   <= divisor;
            rem_r    <= '0;
            cnt      <= '0;
            div_busy <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            // Trivial cases load their final results directly and skip iteration.
            if (divisor == '0) begin
              q_r      <= '1;
              rem_r    <= {1'b0, dividend};
              div_done <= 1'b1;
              state    <= DIV_DONE;
            end else if (dividend < divisor) begin
              q_r      <= '0;
              rem_r    <= {1'b0, dividend};
              div_done <= 1'b1;
              state    <= DIV_DONE;
            end else begin
              state <= DIV_CALC;
            end
`else
            state <= DIV_CALC;
`endif
          end
        end
        DIV_CALC: begin
          q_r   <= q_next;
          rem_r <= rem_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            div_done <= 1'b1;
            state    <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          div_done <= 1'b0;
          div_busy <= 1'b0;
          state    <= DIV_IDLE;
        end
        default: begin
          div_done <= 1'b0;
          div_busy <= 1'b0;
          state    <= DIV_IDLE;
        end
      endcase
    end
  end

  assign quotient  = q_r;
  assign remainder = rem_r[WIDTH-1:0];

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter against an arithmetic (/ and %) reference model.
module tb_div_iter;

  localparam int unsigned WIDTH = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             div_start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_done;
  logic             div_busy;

  int compared = 0;
  int mismatched = 0;

  div_iter #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .div_start (div_start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .div_done  (div_done),
    .div_busy  (div_busy)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issues one operation and checks latency, busy window, results and result hold.
  // poke_cyc > 0 pulses a competing start (9/2) in that cycle while the divider is busy.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int poke_cyc);
    logic [WIDTH-1:0] eq;
    logic [WIDTH-1:0] er;
    int lat;
    int done_cyc;
    bit busy_ok;
    if (b == 0) begin
      eq = '1;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    lat = (EARLY && (b == 0 || a < b)) ? 1 : WIDTH + 1;

    div_start = 1'b1;
    dividend  = a;
    divisor   = b;
    step();
    div_start = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;

    done_cyc = 0;
    busy_ok  = 1'b1;
    for (int c = 1; c <= int'(WIDTH) + 4; c++) begin
      if (div_busy !== 1'b1) busy_ok = 1'b0;
      if (poke_cyc > 0 && c == poke_cyc) begin
        div_start = 1'b1;
        dividend  = 32'd9;
        divisor   = 32'd2;
      end
      if (poke_cyc > 0 && c == poke_cyc + 1) div_start = 1'b0;
      if (div_done === 1'b1) begin
        done_cyc = c;
        break;
      end
      step();
    end
    div_start = 1'b0;

    check("done_cycle", 64'(done_cyc), 64'(lat));
    check("busy_window", 64'(busy_ok), 64'd1);
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));

    step();
    check("busy_after", 64'(div_busy), 64'd0);
    check("done_pulse", 64'(div_done), 64'd0);
    check("quotient_hold", 64'(quotient), 64'(eq));
    check("remainder_hold", 64'(remainder), 64'(er));

    repeat ($urandom_range(0, 3)) step();
    check("quotient_idle", 64'(quotient), 64'(eq));
    check("remainder_idle", 64'(remainder), 64'(er));
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bit seen_done;

    rst_i = 1'b1;
    step();
    step();
    check("rst_busy", 64'(div_busy), 64'd0);
    check("rst_done", 64'(div_done), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    rst_i = 1'b0;
    step();

    run_op(32'd100, 32'd7, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(32'h0000_1234, 32'd0, 0);
    run_op(32'd50, 32'd5, 10);
    run_op(32'd5, 32'd9, 0);
    run_op(32'd90, 32'd9, 0);

    // Reset mid-calculation discards the operation without a done pulse.
    div_start = 1'b1;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    step();
    div_start = 1'b0;
    repeat (14) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("midrst_busy", 64'(div_busy), 64'd0);
    check("midrst_done", 64'(div_done), 64'd0);
    check("midrst_quotient", 64'(quotient), 64'd0);
    check("midrst_remainder", 64'(remainder), 64'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (div_done !== 1'b0 || div_busy !== 1'b0) seen_done = 1'b1;
      step();
    end
    check("midrst_quiet", 64'(seen_done), 64'd0);
    run_op(32'd1000, 32'd3, 0);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = '0;
        default: b = (a == '1) ? 32'hFFFF_FFFF : a + 32'd1 + ($urandom & 32'hFF);
      endcase
      if (b != '0 && b < a && $urandom_range(0, 1) == 0) a = a >> $urandom_range(0, 31);
      run_op(a, b, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative unsigned restoring divider that responds to the `div_start` / `div_done` / `div_busy` handshake issued by the multiply-divide unit in the milano execute stage. It receives magnitude-only operands, since sign correction and result selection stay with the initiator. It produces quotient and remainder after a fixed number of iterations and holds them stable for writeback.

## Interface
- `WIDTH`, default 32: operand and result width. The iteration count equals `WIDTH`.
- `clk_i` input 1: clock. All state updates on the rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `div_start` input 1: start request. Accepted only in IDLE.
- `dividend` input WIDTH: unsigned dividend. Sampled on accept.
- `divisor` input WIDTH: unsigned divisor. Sampled on accept.
- `quotient` output WIDTH: unsigned quotient. Valid from the `div_done` cycle until the next accept.
- `remainder` output WIDTH: unsigned remainder. Same validity as `quotient`.
- `div_done` output 1: single-cycle pulse that marks the results valid.
- `div_busy` output 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE:**
  - `div_start`=1: latch `dividend` into the quotient shift register, latch `divisor`, clear the partial remainder (WIDTH+1 bits), clear the counter, go to CALC.
  - `div_start`=0: stay in IDLE.
- **CALC, one step per cycle:**
  - t = {rem[WIDTH-1:0], q[WIDTH-1]}.
  - If t >= {1'b0, divisor}: rem = t − divisor and shift 1 into q. Otherwise rem = t and shift 0 into q.
  - Increment the counter. After step WIDTH (counter == WIDTH−1 at the edge), go to DONE.
- **DONE:** assert `div_done` and go to IDLE.
- **Result hold:** `quotient` and `remainder` drive the registers directly and are not cleared on return to IDLE.
- **Divide by zero:** the algorithm yields quotient = all ones and remainder = dividend. No special path is needed; both values are required results.
- **Start outside IDLE:** `div_start` in CALC or DONE is ignored. Operand changes during CALC have no effect.
- **Start held through DONE:** a `div_start` still high in the cycle after DONE is accepted as a new operation. The initiator deasserts `div_start` on `div_done`.
- **Reset:** `rst_i` in any state, including mid-CALC, forces IDLE, counter 0, q/rem/divisor registers 0, and therefore `quotient`=0, `remainder`=0, `div_done`=0, `div_busy`=0. The in-flight operation is discarded without `div_done`.

## Timing
- Cycle 0 is the accept edge (IDLE with `div_start`=1).
- Cycles 1..WIDTH are CALC, and `div_busy`=1.
- Cycle WIDTH+1 is DONE: `div_done`=1, `div_busy`=1, results valid.
- Cycle WIDTH+2 is IDLE: `div_busy`=0, results still valid.
- Latency from accept to `div_done` is WIDTH+1 cycles (33 for WIDTH=32).
- Minimum start-to-start spacing is WIDTH+2 cycles.
- `div_done` and `div_busy` are registered state decodes with no combinational path from inputs.

## Configuration
- **Macro:** `DIV_EARLY_OUT_EN`.
- **Defined:**
  - On accept, if divisor == 0 or dividend < divisor, skip CALC and go directly to DONE.
  - Results load in the same edge:
    - divisor == 0: quotient = all ones, remainder = dividend.
    - dividend < divisor: quotient = 0, remainder = dividend.
  - `div_done` asserts in cycle 1, and `div_busy`=1 for that single cycle.
- **Undefined:** every operation takes WIDTH+1 cycles. Results are identical in both builds; only latency differs.

## Structure
- **`milano_pkg`:**
  - `div_state_e` enum {DIV_IDLE, DIV_CALC, DIV_DONE}.
  - `DIV_WIDTH` = 32 constant.
  - Counter width derived as $clog2(WIDTH).
- **Sub-module `div_iter_step`:** one natural combinational sub-module.
  - Inputs: rem, q, divisor.
  - Outputs: next rem and next q, covering the compare, subtract and shift of one restoring step.
  - Instantiated once in the iterative datapath.

## Test plan
- dividend=100, divisor=7, start pulsed 1 cycle -> `div_busy` cycles 1..33, `div_done` in cycle 33 only, quotient=14, remainder=2. Both hold until the next start.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. dividend=0x80000000, divisor=0xFFFFFFFF -> quotient=0, remainder=0x80000000.
- dividend=0x1234, divisor=0 -> quotient=0xFFFFFFFF, remainder=0x1234. Done in cycle 33, or cycle 1 with `DIV_EARLY_OUT_EN`.
- Start 50/5, then pulse start with 9/2 at cycle 10 while busy -> second start ignored, quotient=10, remainder=0 at cycle 33.
- Start 1000/3, assert `rst_i` at cycle 15 -> cycle 16 `div_busy`=0, quotient=0, remainder=0, no `div_done`. New start 1000/3 afterwards -> quotient=333, remainder=1.
- `DIV_EARLY_OUT_EN` defined, dividend=5, divisor=9 -> `div_done` in cycle 1, quotient=0, remainder=5. Then 90/9 -> normal 33-cycle latency, quotient=10, remainder=0.
